// File: rtl/text_writer.sv
// text_writer: writer side of the VGA text buffer; turns an ASCII byte stream into
// character-memory writes with cursor tracking, line wrap, line clearing and scroll pulses.
module text_writer #(
   parameter int h_disp = 1280,
   parameter int v_disp = 1024,
   localparam int h_chars = h_disp / 8,
   localparam int v_chars = v_disp / 8,
   localparam int max_chars = h_chars * v_chars,
   localparam int char_addr_width = $clog2(max_chars)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [7:0]                 in_char,
   output logic                       in_ready,
   output logic                       wr_en,
   output logic [char_addr_width-1:0] wr_addr,
   output logic [7:0]                 wr_data,
   output logic                       scroll,
   output logic [char_addr_width-1:0] cursor_addr
);
   localparam int aw = char_addr_width;
   localparam int cw = $clog2(h_chars);
   localparam int rw = $clog2(v_chars);
   localparam int nw = $clog2(h_chars + 1);

   typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;

   state_t         state;
   logic [cw-1:0]  col;
   logic [rw-1:0]  row;
   logic [aw-1:0]  line_start;
   logic [nw-1:0]  clr;
   logic           scr_pend;
   logic [aw-1:0]  next_ls;
   logic           last_row;
   logic           printable;
   logic           wrap;

   always_comb begin
      next_ls   = (line_start >= aw'(max_chars - h_chars)) ? '0 : line_start + aw'(h_chars);
      last_row  = row == rw'(v_chars - 1);
      printable = in_char >= 8'h20 && in_char <= 8'h7e;
      wrap      = col == cw'(h_chars - 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= INIT;
         in_ready    <= 1'b0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= 8'h20;
         scroll      <= 1'b0;
         cursor_addr <= '0;
         col         <= '0;
         row         <= '0;
         line_start  <= '0;
         clr         <= '0;
         scr_pend    <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               if (wr_en && wr_addr == aw'(max_chars - 1)) begin
                  wr_en    <= 1'b0;
                  in_ready <= 1'b1;
                  state    <= IDLE;
               end else begin
                  wr_en   <= 1'b1;
                  wr_addr <= wr_en ? wr_addr + 1'b1 : '0;
                  wr_data <= 8'h20;
               end
            end
            IDLE: begin
               wr_en  <= 1'b0;
               scroll <= 1'b0;
               if (in_valid) begin
                  if (printable) begin
                     wr_en   <= 1'b1;
                     wr_addr <= cursor_addr;
                     wr_data <= in_char;
                  end
                  if (printable && !wrap) begin
                     col         <= col + 1'b1;
                     cursor_addr <= cursor_addr + 1'b1;
                  end else if (printable || in_char == 8'h0a) begin
                     col         <= '0;
                     line_start  <= next_ls;
                     cursor_addr <= next_ls;
                     in_ready    <= 1'b0;
                     state       <= CLEAR;
                     scr_pend    <= last_row;
                     if (!last_row) row <= row + 1'b1;
                     // a bare newline starts clearing right away; a wrapping printable writes itself first
                     clr <= printable ? nw'(0) : nw'(1);
                     if (!printable) begin
                        wr_en   <= 1'b1;
                        wr_addr <= next_ls;
                        wr_data <= 8'h20;
                        scroll  <= last_row;
                     end
                  end else if (in_char == 8'h0d) begin
                     col         <= '0;
                     cursor_addr <= line_start;
                  end else if (in_char == 8'h08 && col != '0) begin
                     col         <= col - 1'b1;
                     cursor_addr <= cursor_addr - 1'b1;
                     wr_en       <= 1'b1;
                     wr_addr     <= cursor_addr - 1'b1;
                     wr_data     <= 8'h20;
                  end
               end
            end
            CLEAR: begin
               if (clr == nw'(h_chars)) begin
                  wr_en    <= 1'b0;
                  scroll   <= 1'b0;
                  in_ready <= 1'b1;
                  state    <= IDLE;
               end else begin
                  wr_en   <= 1'b1;
                  wr_addr <= line_start + aw'(clr);
                  wr_data <= 8'h20;
                  scroll  <= scr_pend && clr == '0;
                  clr     <= clr + 1'b1;
               end
            end
            default: state <= INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_text_writer.sv
// tb_text_writer: randomized byte stream checked against a text-screen reference model.
module tb_text_writer;
   localparam int H = 160;
   localparam int V = 128;
   localparam int MAX = H * V;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_char = 8'h00;
   logic        in_ready;
   logic        wr_en;
   logic [14:0] wr_addr;
   logic [7:0]  wr_data;
   logic        scroll;
   logic [14:0] cursor_addr;

   text_writer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_char(in_char),
      .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .scroll(scroll), .cursor_addr(cursor_addr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [7:0]  shadow [MAX];
   logic [7:0]  mem [MAX];
   logic [31:0] got_q [$];
   logic [31:0] exp_q [$];
   bit          logging = 0;
   int          scr_n = 0;
   int          scr_addr = -1;
   int          exp_scr_n = 0;
   int          exp_scr_addr = -1;
   int          mcol = 0, mrow = 0, mls = 0;

   always @(negedge clk) begin
      if (wr_en) begin
         shadow[wr_addr] = wr_data;
         if (logging) got_q.push_back(32'({wr_addr, wr_data}));
      end
      if (scroll) begin
         scr_n++;
         scr_addr = int'(wr_addr);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic put(input int a, input logic [7:0] d);
      mem[a] = d;
      exp_q.push_back(32'({15'(a), d}));
   endtask

   // screen model: cursor as (line_start, col, row), newline opens and blanks the next line
   task automatic model(input logic [7:0] ch, output bit nl);
      nl = 0;
      if (ch >= 8'h20 && ch <= 8'h7e) begin
         put(mls + mcol, ch);
         mcol++;
         if (mcol == H) nl = 1;
      end else if (ch == 8'h0a) nl = 1;
      else if (ch == 8'h0d) mcol = 0;
      else if (ch == 8'h08 && mcol > 0) begin
         mcol--;
         put(mls + mcol, 8'h20);
      end
      if (nl) begin
         mcol = 0;
         mls = (mls + H) % MAX;
         if (mrow < V - 1) mrow++;
         else begin
            exp_scr_n++;
            exp_scr_addr = mls;
         end
         for (int i = 0; i < H; i++) put(mls + i, 8'h20);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!in_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(in_ready), 32'd1);
   endtask

   task automatic send(input logic [7:0] ch);
      bit nl;
      int bad = 0;
      wait_ready("ready_before");
      in_valid = 1'b1;
      in_char = ch;
      @(posedge clk);
      #1 in_valid = 1'b0;
      in_char = 8'($urandom);
      model(ch, nl);
      @(negedge clk);
      chk("cursor_now", 32'(cursor_addr), 32'(mls + mcol));
      chk("ready_now", 32'(in_ready), 32'(!nl));
      wait_ready("ready_after");
      #2;
      chk("wr_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) bad++;
      chk("wr_seq_errors", 32'(bad), 32'd0);
      chk("scroll_count", 32'(scr_n), 32'(exp_scr_n));
      if (nl && exp_scr_addr == mls) chk("scroll_addr", 32'(scr_addr), 32'(mls));
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int bad;
      int r;
      logic [7:0] ch;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'h20);
      chk("rst_scroll", 32'(scroll), 32'd0);
      chk("rst_cursor", 32'(cursor_addr), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("init_first_en", 32'(wr_en), 32'd1);
      chk("init_first_addr", 32'(wr_addr), 32'd0);
      bad = 0;
      for (int i = 1; i < MAX; i++) begin
         @(negedge clk);
         if (!wr_en || wr_addr != 15'(i) || wr_data != 8'h20 || in_ready) bad++;
      end
      chk("init_seq_errors", 32'(bad), 32'd0);
      @(negedge clk);
      chk("init_done_en", 32'(wr_en), 32'd0);
      chk("init_done_ready", 32'(in_ready), 32'd1);
      chk("init_done_cursor", 32'(cursor_addr), 32'd0);
      chk("init_done_scroll", 32'(scroll), 32'd0);
      for (int i = 0; i < MAX; i++) mem[i] = 8'h20;
      logging = 1;

      send(8'h41);
      send(8'h42);
      chk("ab_cursor", 32'(cursor_addr), 32'd2);
      send(8'h0d);
      for (int i = 0; i < H; i++) send(8'h78);
      chk("wrap_cursor", 32'(cursor_addr), 32'd160);
      chk("wrap_no_scroll", 32'(scr_n), 32'd0);
      for (int i = 0; i < V; i++) send(8'h0a);
      chk("scroll_seen", 32'(scr_n > 0), 32'd1);
      send(8'h61);
      send(8'h62);
      send(8'h63);
      send(8'h08);
      send(8'h0d);
      send(8'h08);
      send(8'h07);
      for (int i = 0; i < 250; i++) begin
         r = int'($urandom_range(0, 9));
         ch = (r < 6) ? 8'($urandom_range(8'h20, 8'h7e)) :
              (r == 6) ? 8'h0a : (r == 7) ? 8'h0d : (r == 8) ? 8'h08 :
              8'($urandom_range(0, 1) ? $urandom_range(8'h7f, 8'hff) : $urandom_range(0, 8'h1f));
         send(ch);
      end
      bad = 0;
      for (int i = 0; i < MAX; i++) if (shadow[i] !== mem[i]) bad++;
      chk("mem_image_errors", 32'(bad), 32'd0);

      logging = 0;
      wait_ready("ready_pre_rst");
      in_valid = 1'b1;
      in_char = 8'h0a;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid_clear_en", 32'(wr_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_wr_en", 32'(wr_en), 32'd0);
      chk("async_scroll", 32'(scroll), 32'd0);
      chk("async_ready", 32'(in_ready), 32'd0);
      chk("async_cursor", 32'(cursor_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reinit_en", 32'(wr_en), 32'd1);
      chk("reinit_addr0", 32'(wr_addr), 32'd0);
      @(negedge clk);
      chk("reinit_addr1", 32'(wr_addr), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
